// File: rtl/sel_arbiter_ctrl_if.sv
// Requester-side bundle of the shared select-decoder arbiter: requests and
// releases in, decoder select/enable, grant and status out.
interface sel_arbiter_ctrl_if;
    logic [1:0] req;
    logic [1:0] done;
    logic       sel;
    logic       en;
    logic [1:0] gnt;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done,
        input  sel, en, gnt, busy, timeout
    );

    modport slave (
        input  req, done,
        output sel, en, gnt, busy, timeout
    );
endinterface

// File: rtl/sel_arbiter_ctrl.sv
// Two-requester round-robin arbiter for the 1-to-2 select decoder, with a
// bounded hold per grant and a fixed turnaround gap between owners.
module sel_arbiter_ctrl #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned TURN     = 1,
    parameter int unsigned CW       = 5
) (
    input  logic                clk,
    input  logic                rst,
    sel_arbiter_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);

    state_t        state, state_d;
    logic          sel_q, sel_d;
    logic          en_q, en_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          last, last_d;

    logic          winner;
    logic          owner_done;
    logic          owner_req;
    logic          at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel_q     <= 1'b0;
            en_q      <= 1'b0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt       <= '0;
            last      <= 1'b1;
        end else begin
            state     <= state_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt       <= cnt_d;
            last      <= last_d;
        end
    end

    always_comb begin
        state_d    = state;
        sel_d      = sel_q;
        en_d       = en_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        cnt_d      = cnt;
        last_d     = last;
        winner     = (bus.req == 2'b11) ? ~last : bus.req[1];
        owner_done = bus.done[sel_q];
        owner_req  = bus.req[sel_q];
        at_limit   = (cnt == HOLD_LAST);

        unique case (state)
            ST_IDLE: begin
                sel_d  = 1'b0;
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (bus.req != 2'b00) begin
                    sel_d   = winner;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = winner;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (owner_done || !owner_req || at_limit) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_TURN;
                    // Timeout flags only a forced revoke, not a coincident release.
                    timeout_d = at_limit && !owner_done && owner_req;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt == TURN_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sel_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 1'b0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        gnt_d = {en_d & sel_d, en_d & ~sel_d};
    end

    assign bus.sel     = sel_q;
    assign bus.en      = en_q;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_sel_arbiter_ctrl.sv
// Randomized and directed bench for sel_arbiter_ctrl against an
// ownership/gap reference model.
module tb_sel_arbiter_ctrl;

    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned TURN     = 2;

    logic clk = 1'b0;
    logic rst;

    sel_arbiter_ctrl_if bus ();

    sel_arbiter_ctrl #(
        .MAX_HOLD (MAX_HOLD),
        .TURN     (TURN),
        .CW       (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;

    // Reference model: who owns the decoder, for how long, and how much gap remains.
    int  m_owner;
    int  m_age;
    int  m_gap;
    int  m_last;
    int  m_sel;
    bit  m_tmo;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge(input logic [1:0] r, input logic [1:0] d, input logic rs);
        bit release_now;
        bit limit_now;
        if (rs) begin
            m_owner = -1; m_age = 0; m_gap = 0; m_last = 1; m_sel = 0; m_tmo = 0;
        end else if (m_owner >= 0) begin
            release_now = d[m_owner] || !r[m_owner];
            limit_now   = (m_age == MAX_HOLD);
            if (release_now || limit_now) begin
                m_tmo   = limit_now && !release_now;
                m_owner = -1;
                m_gap   = TURN;
            end else begin
                m_tmo = 0;
                m_age++;
            end
        end else if (m_gap > 0) begin
            m_tmo = 0;
            m_gap--;
            if (m_gap == 0) m_sel = 0;
        end else begin
            m_tmo = 0;
            if (r != 2'b00) begin
                m_owner = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
                m_last  = m_owner;
                m_sel   = m_owner;
                m_age   = 1;
            end
        end
    endtask

    task automatic step(input logic [1:0] r, input logic [1:0] d, input logic rs);
        logic [1:0] exp_gnt;
        bus.req  = r;
        bus.done = d;
        rst      = rs;
        @(posedge clk);
        model_edge(r, d, rs);
        #1;
        exp_gnt = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        check_eq("sel",     8'(bus.sel),     8'(m_sel));
        check_eq("en",      8'(bus.en),      8'(m_owner >= 0));
        check_eq("gnt",     8'(bus.gnt),     8'(exp_gnt));
        check_eq("busy",    8'(bus.busy),    8'((m_owner >= 0) || (m_gap > 0)));
        check_eq("timeout", 8'(bus.timeout), 8'(m_tmo));
    endtask

    task automatic repeat_step(input int n, input logic [1:0] r, input logic [1:0] d);
        for (int i = 0; i < n; i++) step(r, d, 1'b0);
    endtask

    initial begin
        logic [1:0] r;
        logic [1:0] d;
        logic       rs;
        rst      = 1'b1;
        bus.req  = 2'b00;
        bus.done = 2'b00;

        // Reset, single request, owner release.
        step(2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b00, 1'b1);
        repeat_step(2, 2'b01, 2'b00);
        step(2'b01, 2'b01, 1'b0);
        repeat_step(5, 2'b00, 2'b00);

        // Continuous contention: alternating grants with timeouts.
        repeat_step(24, 2'b11, 2'b00);
        repeat_step(5, 2'b00, 2'b00);

        // Requester 1 drops its request mid-grant.
        repeat_step(3, 2'b10, 2'b00);
        repeat_step(5, 2'b00, 2'b00);

        // Non-owner done is ignored.
        repeat_step(2, 2'b11, 2'b00);
        step(2'b11, 2'b10, 1'b0);
        repeat_step(10, 2'b11, 2'b00);

        // Reset mid-grant with both requesting.
        repeat_step(6, 2'b11, 2'b00);
        step(2'b11, 2'b00, 1'b1);
        repeat_step(6, 2'b11, 2'b00);
        repeat_step(5, 2'b00, 2'b00);

        // Owner done coinciding with the hold limit.
        repeat_step(3, 2'b01, 2'b00);
        step(2'b01, 2'b01, 1'b0);
        repeat_step(5, 2'b00, 2'b00);

        // Random traffic with sticky requests, sporadic done and resets.
        r = 2'b00;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (r[b]) r[b] = ($urandom_range(7) != 0);
                else      r[b] = ($urandom_range(2) == 0);
                d[b] = ($urandom_range(5) == 0);
            end
            rs = ($urandom_range(59) == 0);
            step(r, d, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
